// File: rtl/apb_master_bridge.sv
// Command-port to APB4 master: one transfer per accepted command, SETUP then ACCESS, response pulse after completion.
// Latency accept->rsp_valid = 2 + wait states; cmd_ready is high only in IDLE, so commands stall upstream while a transfer is in flight.
module apb_master_bridge #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_SIZE-1:0]   cmd_addr,
  input  logic [DATA_SIZE-1:0]   cmd_wdata,
  input  logic [DATA_SIZE/8-1:0] cmd_strobe,
  output logic                   rsp_valid,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic [DATA_SIZE/8-1:0] PSTROBE,
  input  logic                   PREADY,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PSLVERR
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_inc;
  logic          timeout_hit;

  always_comb begin
    wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    // The wait cycle being sampled now is the one that makes the count reach TIMEOUT.
    timeout_hit  = (TIMEOUT != 0) && (wait_cnt >= CNT_LAST);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTROBE     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b1;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_write ? cmd_wdata : '0;
            PSTROBE   <= cmd_write ? cmd_strobe : '0;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (PREADY) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (timeout_hit) begin
              state       <= IDLE;
              cmd_ready   <= 1'b1;
              PSEL        <= 1'b0;
              PENABLE     <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: randomized commands against a reference memory model, APB slave model with wait/error injection.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strobe = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [5:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTROBE;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;
  logic        PSLVERR = 1'b0;

  apb_master_bridge #(.DATA_SIZE(32), .ADDR_SIZE(6), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTROBE(PSTROBE), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          access;
  } exp_t;

  typedef struct {
    int   waits;
    logic err;
  } cfg_t;

  exp_t        exp_q[$];
  cfg_t        cfg_q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] smem [64];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: one response per command, decided at issue time from the abstract rules.
  task automatic issue(input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input int waits, input logic err, input bit exp_rsp);
    exp_t e;
    cfg_t c;
    int   n;
    @(negedge PCLK);
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    cmd_strobe = st;
    c.waits = waits;
    c.err   = err;
    cfg_q.push_back(c);
    if (exp_rsp) begin
      e.wr    = wr;
      e.addr  = addr;
      e.wdata = wr ? wd : 32'h0;
      e.strb  = wr ? st : 4'h0;
      if (waits >= TIMEOUT) begin
        e.rdata = 32'h0; e.err = 1'b1; e.tmo = 1'b1; e.access = TIMEOUT;
      end else begin
        e.err = err; e.tmo = 1'b0; e.access = waits + 1;
        if (wr) begin
          e.rdata = 32'h0;
          if (!err)
            for (int b = 0; b < 4; b++)
              if (st[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
        end else begin
          e.rdata = ref_mem[addr];
        end
      end
      exp_q.push_back(e);
    end
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk("accept", 64'(cmd_ready), 64'd1);
    @(posedge PCLK);
    #1;
    cmd_valid  = 1'b0;
    cmd_wdata  = $urandom;
    cmd_addr   = 6'($urandom);
    cmd_strobe = 4'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // APB slave model with per-transfer wait states and error injection.
  bit   s_active = 0;
  int   s_wcnt = 0;
  cfg_t s_cur;
  always @(negedge PCLK) begin
    if (!PRESETn || !(PSEL && PENABLE)) begin
      s_active = 0;
      PREADY   = 1'b0;
    end else begin
      if (!s_active) begin
        s_active = 1;
        s_wcnt   = 0;
        if (cfg_q.size() != 0) s_cur = cfg_q.pop_front();
        else begin s_cur.waits = 0; s_cur.err = 1'b0; end
      end
      if (s_wcnt >= s_cur.waits) begin
        PREADY  = 1'b1;
        PSLVERR = s_cur.err;
        PRDATA  = PWRITE ? $urandom : smem[PADDR];
        if (PWRITE && !s_cur.err)
          for (int b = 0; b < 4; b++)
            if (PSTROBE[b]) smem[PADDR][8*b +: 8] = PWDATA[8*b +: 8];
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end
      s_wcnt++;
    end
  end

  // Monitor: APB field stability while selected, response checks against the scoreboard.
  int          pen_cnt = 0;
  int          psel_cnt = 0;
  logic [5:0]  last_addr = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        last_tmo = 1'b0;
  exp_t        m_e;
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      pen_cnt = 0; psel_cnt = 0;
      last_addr = '0; last_rdata = '0; last_err = 1'b0; last_tmo = 1'b0;
    end else begin
      if (PENABLE) pen_cnt++;
      if (PSEL) psel_cnt++;
      if (PSEL && exp_q.size() != 0) begin
        chk("apb_fields", 64'({PWRITE, PADDR, PWDATA, PSTROBE}),
            64'({exp_q[0].wr, exp_q[0].addr, exp_q[0].wdata, exp_q[0].strb}));
        chk("busy_ready", 64'(cmd_ready), 64'd0);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(m_e.err));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(m_e.tmo));
          chk("access_cycles", 64'(pen_cnt), 64'(m_e.access));
          chk("psel_cycles", 64'(psel_cnt), 64'(m_e.access + 1));
          chk("idle_after_rsp", 64'({cmd_ready, PSEL, PENABLE}), 64'b100);
          last_addr = m_e.addr; last_rdata = m_e.rdata; last_err = m_e.err; last_tmo = m_e.tmo;
        end
        pen_cnt = 0;
        psel_cnt = 0;
      end else begin
        chk("rsp_hold", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({last_rdata, last_err, last_tmo}));
      end
      if (!PSEL) chk("paddr_hold", 64'(PADDR), 64'(last_addr));
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'h0;
      smem[i]    = 32'h0;
    end
    repeat (3) @(negedge PCLK);
    chk("reset_in", 64'({cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE}), 64'b10000);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("reset_out", 64'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE}), 64'b100000);
    chk("reset_bus", 64'({PADDR, PWDATA, PSTROBE, rsp_rdata}), 64'd0);

    // Full write, then read back; byte-strobed overwrite
    issue(1'b1, 6'h05, 32'h5555_5555, 4'hF, 0, 1'b0, 1);
    issue(1'b0, 6'h05, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1);
    issue(1'b1, 6'h05, 32'hFFFF_FFFF, 4'b0011, 0, 1'b0, 1);
    issue(1'b0, 6'h05, 32'h0, 4'h0, 1, 1'b0, 1);
    // Read with 3 wait states
    issue(1'b1, 6'h06, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 1);
    issue(1'b0, 6'h06, 32'h1234_5678, 4'hF, 3, 1'b0, 1);
    // Slave error on write to top address
    issue(1'b1, 6'h3F, 32'h0BAD_F00D, 4'hF, 0, 1'b1, 1);
    issue(1'b0, 6'h3F, 32'h0, 4'h0, 0, 1'b0, 1);
    // Timeouts, and completion on the last allowed cycle
    issue(1'b0, 6'h05, 32'h0, 4'h0, TIMEOUT, 1'b0, 1);
    issue(1'b1, 6'h07, 32'hCAFE_0001, 4'hF, TIMEOUT + 3, 1'b0, 1);
    issue(1'b0, 6'h05, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 1);
    issue(1'b0, 6'h07, 32'h0, 4'h0, 0, 1'b0, 1);
    wait_drain();

    // Reset asserted in the middle of ACCESS
    issue(1'b1, 6'h2A, 32'h1234_5678, 4'hF, 50, 1'b0, 0);
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("rst_access_reached", 64'(PENABLE), 64'd1);
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1 chk("rst_drop", 64'({PSEL, PENABLE, rsp_valid}), 64'd0);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst_release", 64'({cmd_ready, rsp_valid, PSEL}), 64'b100);
    issue(1'b0, 6'h00, 32'h0, 4'h0, 0, 1'b0, 1);
    issue(1'b0, 6'h2A, 32'h0, 4'h0, 0, 1'b0, 1);
    wait_drain();

    for (int i = 0; i < 200; i++) begin
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] wd;
      logic [3:0]  st;
      int          w;
      logic        er;
      wr   = 1'($urandom_range(0, 1));
      addr = 6'($urandom_range(0, 63));
      wd   = $urandom;
      st   = 4'($urandom_range(0, 15));
      w    = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
      er   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge PCLK);
      issue(wr, addr, wd, st, w, er, 1);
    end
    wait_drain();
    repeat (3) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
